instr_realigner: RTL and testbench

Frontend stage between the instruction fetch buffer and the compressed decoder. It accepts 32-bit fetch words, which are aligned to 4 bytes but may be entered at a halfword offset after a jump. From these words it extracts one RISC-V instruction per handshake, 16-bit or 32-bit, at halfword granularity. It stitches 32-bit instructions that straddle two fetch words and emits each instruction with its own PC.

---
 rtl/ariane_pkg.sv | 18 +
 rtl/realign_out_reg.sv | 47 ++++
 rtl/instr_realigner.sv | 125 ++++++++++++
 tb/tb_instr_realigner.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - shared frontend types and widths for the instruction realigner
package ariane_pkg;

   localparam int unsigned VLEN         = 64;
   localparam int unsigned INSTR_HALF_W = 16;

   typedef enum logic [1:0] {
      S_LO,
      S_HI,
      S_STRADDLE
   } realign_state_e;

   // RVC encodings are every halfword whose two low bits are not 2'b11.
   function automatic logic is_rvc(input logic [INSTR_HALF_W-1:0] half);
      return half[1:0] != 2'b11;
   endfunction

endpackage

// File: rtl/realign_out_reg.sv
// rtl/realign_out_reg.sv - single-entry output register, used only with INSTR_REALIGNER_OUT_REG_EN
module realign_out_reg #(
   parameter int unsigned VLEN = 64
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            in_valid_i,
   input  logic [31:0]     in_instr_i,
   input  logic [VLEN-1:0] in_addr_i,
   output logic            in_ready_o,
   output logic            out_valid_o,
   output logic [31:0]     out_instr_o,
   output logic [VLEN-1:0] out_addr_o,
   output logic            out_is_compressed_o,
   input  logic            out_ready_i
);

   logic            valid_q;
   logic [31:0]     instr_q;
   logic [VLEN-1:0] addr_q;

   // Accept a new entry whenever the slot is empty or drains this cycle.
   assign in_ready_o = !valid_q || out_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         addr_q  <= '0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (in_valid_i && in_ready_o) begin
         valid_q <= 1'b1;
         instr_q <= in_instr_i;
         addr_q  <= in_addr_i;
      end else if (out_ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign out_valid_o         = valid_q;
   assign out_instr_o         = instr_q;
   assign out_addr_o          = addr_q;
   assign out_is_compressed_o = valid_q && (instr_q[1:0] != 2'b11);

endmodule

// File: rtl/instr_realigner.sv
// rtl/instr_realigner.sv - halfword realigner from fetch words to single instructions (option: INSTR_REALIGNER_OUT_REG_EN)
module instr_realigner #(
   parameter int unsigned VLEN = ariane_pkg::VLEN
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            fetch_valid_i,
   input  logic [31:0]     fetch_data_i,
   input  logic [VLEN-1:0] fetch_addr_i,
   output logic            fetch_ready_o,
   output logic            instr_valid_o,
   output logic [31:0]     instr_o,
   output logic [VLEN-1:0] instr_addr_o,
   output logic            instr_is_compressed_o,
   input  logic            instr_ready_i
);
   import ariane_pkg::*;

   realign_state_e          state_q, state_d;
   logic [INSTR_HALF_W-1:0] pend_q, pend_d;
   logic [VLEN-1:0]         pend_addr_q, pend_addr_d;

   logic                    fsm_valid;
   logic                    fsm_ready;
   logic [31:0]             fsm_instr;
   logic [VLEN-1:0]         fsm_addr;
   logic [VLEN-1:0]         base_addr;
   logic [INSTR_HALF_W-1:0] lo_half, hi_half;
   logic                    unused_addr_bit0;

   assign base_addr        = {fetch_addr_i[VLEN-1:2], 2'b00};
   assign lo_half          = fetch_data_i[15:0];
   assign hi_half          = fetch_data_i[31:16];
   assign unused_addr_bit0 = fetch_addr_i[0];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_LO;
         pend_q      <= '0;
         pend_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pend_d        = pend_q;
      pend_addr_d   = pend_addr_q;
      fsm_valid     = 1'b0;
      fsm_instr     = '0;
      fsm_addr      = '0;
      fetch_ready_o = 1'b0;

      if (flush_i) begin
         state_d       = S_LO;
         pend_d        = '0;
         pend_addr_d   = '0;
         fetch_ready_o = 1'b1;
      end else if (fetch_valid_i) begin
         if (state_q == S_STRADDLE) begin
            fsm_valid = 1'b1;
            fsm_instr = {lo_half, pend_q};
            fsm_addr  = pend_addr_q;
            if (fsm_ready) state_d = S_HI;
         end else if (state_q == S_HI || fetch_addr_i[1]) begin
            // Jump targets at a halfword offset enter here straight from S_LO.
            if (is_rvc(hi_half)) begin
               fsm_valid = 1'b1;
               fsm_instr = {16'h0000, hi_half};
               fsm_addr  = base_addr + VLEN'(2);
               if (fsm_ready) begin
                  fetch_ready_o = 1'b1;
                  state_d       = S_LO;
               end
            end else begin
               // Upper half starts a 32-bit instruction: park it, no emission.
               fetch_ready_o = 1'b1;
               pend_d        = hi_half;
               pend_addr_d   = base_addr + VLEN'(2);
               state_d       = S_STRADDLE;
            end
         end else begin
            fsm_valid = 1'b1;
            fsm_addr  = base_addr;
            if (is_rvc(lo_half)) begin
               fsm_instr = {16'h0000, lo_half};
               if (fsm_ready) state_d = S_HI;
            end else begin
               fsm_instr = fetch_data_i;
               if (fsm_ready) fetch_ready_o = 1'b1;
            end
         end
      end
   end

`ifdef INSTR_REALIGNER_OUT_REG_EN
   realign_out_reg #(
      .VLEN (VLEN)
   ) u_out_reg (
      .clk_i               (clk_i),
      .rst_ni              (rst_ni),
      .flush_i             (flush_i),
      .in_valid_i          (fsm_valid),
      .in_instr_i          (fsm_instr),
      .in_addr_i           (fsm_addr),
      .in_ready_o          (fsm_ready),
      .out_valid_o         (instr_valid_o),
      .out_instr_o         (instr_o),
      .out_addr_o          (instr_addr_o),
      .out_is_compressed_o (instr_is_compressed_o),
      .out_ready_i         (instr_ready_i)
   );
`else
   assign fsm_ready             = instr_ready_i;
   assign instr_valid_o         = fsm_valid;
   assign instr_o               = fsm_instr;
   assign instr_addr_o          = fsm_addr;
   assign instr_is_compressed_o = fsm_valid && (fsm_instr[1:0] != 2'b11);
`endif

endmodule

// File: tb/tb_instr_realigner.sv
// tb/tb_instr_realigner.sv - self-checking bench for instr_realigner, default build
module tb_instr_realigner;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        fvalid;
   logic [31:0] fdata;
   logic [63:0] faddr;
   logic        fready;
   logic        ivalid;
   logic [31:0] instr;
   logic [63:0] iaddr;
   logic        icomp;
   logic        iready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   instr_realigner #(.VLEN(64)) dut (
      .clk_i                 (clk),
      .rst_ni                (rst_n),
      .flush_i               (flush),
      .fetch_valid_i         (fvalid),
      .fetch_data_i          (fdata),
      .fetch_addr_i          (faddr),
      .fetch_ready_o         (fready),
      .instr_valid_o         (ivalid),
      .instr_o               (instr),
      .instr_addr_o          (iaddr),
      .instr_is_compressed_o (icomp),
      .instr_ready_i         (iready)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change just after the falling edge; outputs are sampled 1ns later.
   task automatic drive(input logic v, input logic [31:0] d, input logic [63:0] a,
                        input logic r, input logic f);
      @(negedge clk);
      fvalid = v;
      fdata  = d;
      faddr  = a;
      iready = r;
      flush  = f;
      #1;
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [31:0] i,
                             input logic [63:0] a, input logic fr);
      chk({tag, "_valid"}, 64'(ivalid), 64'(v));
      chk({tag, "_fready"}, 64'(fready), 64'(fr));
      if (v) begin
         chk({tag, "_instr"}, 64'(instr), 64'(i));
         chk({tag, "_addr"}, iaddr, a);
         chk({tag, "_comp"}, 64'(icomp), 64'(i[1:0] != 2'b11));
      end
   endtask

   // Reference: flatten the words into a halfword stream and parse it as RISC-V.
   task automatic run_random(input logic [63:0] base0, input logic off, input int n);
      logic [31:0] words[$];
      logic [15:0] hq[$];
      logic [63:0] haq[$];
      logic [31:0] eiq[$];
      logic [63:0] eaq[$];
      logic [31:0] w;
      logic [31:0] ei;
      logic [63:0] ea;
      int          i;
      int          widx;
      int          cyc;
      logic        v;

      for (int k = 0; k < n; k++) begin
         w = $urandom;
         if ($urandom_range(0, 1) == 1) w[1:0] = 2'b11;
         if ($urandom_range(0, 1) == 1) w[17:16] = 2'b11;
         words.push_back(w);
         if (!(k == 0 && off)) begin
            hq.push_back(w[15:0]);
            haq.push_back(base0 + 64'(4 * k));
         end
         hq.push_back(w[31:16]);
         haq.push_back(base0 + 64'(4 * k) + 64'd2);
      end
      i = 0;
      while (i < hq.size()) begin
         if (hq[i][1:0] != 2'b11) begin
            eiq.push_back({16'h0000, hq[i]});
            eaq.push_back(haq[i]);
            i = i + 1;
         end else if (i + 1 < hq.size()) begin
            eiq.push_back({hq[i + 1], hq[i]});
            eaq.push_back(haq[i]);
            i = i + 2;
         end else begin
            i = hq.size();
         end
      end

      drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b1);
      widx = 0;
      cyc  = 0;
      while (widx < n && cyc < 40 * n) begin
         v = ($urandom_range(0, 3) != 0);
         drive(v, words[widx],
               (widx == 0) ? (base0 | {62'b0, off, 1'b0}) : base0 + 64'(4 * widx),
               ($urandom_range(0, 3) != 0), 1'b0);
         if (!v) chk("rnd_idle_valid", 64'(ivalid), 64'd0);
         if (ivalid && iready) begin
            chk("rnd_expected_pending", 64'(eiq.size() != 0), 64'd1);
            if (eiq.size() != 0) begin
               ei = eiq.pop_front();
               ea = eaq.pop_front();
               chk("rnd_instr", 64'(instr), 64'(ei));
               chk("rnd_addr", iaddr, ea);
               chk("rnd_comp", 64'(icomp), 64'(ei[1:0] != 2'b11));
            end
         end
         if (fready && fvalid) widx++;
         cyc++;
      end
      chk("rnd_words_consumed", 64'(widx), 64'(n));
      chk("rnd_leftover", 64'(eiq.size()), 64'd0);
      drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b1);
      drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
   endtask

   initial begin
      rst_n  = 1'b0;
      flush  = 1'b0;
      fvalid = 1'b0;
      fdata  = '0;
      faddr  = '0;
      iready = 1'b0;
      #1;
      chk("rst_valid", 64'(ivalid), 64'd0);
      chk("rst_fready", 64'(fready), 64'd0);
      chk("rst_instr", 64'(instr), 64'd0);
      chk("rst_addr", iaddr, 64'd0);
      chk("rst_comp", 64'(icomp), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      drive(1'b1, 32'h0000_0513, 64'h1000, 1'b1, 1'b0);
      expect_out("aligned32", 1'b1, 32'h0000_0513, 64'h1000, 1'b1);

      drive(1'b1, 32'h4505_4501, 64'h1000, 1'b1, 1'b0);
      expect_out("pair_c0", 1'b1, 32'h0000_4501, 64'h1000, 1'b0);
      drive(1'b1, 32'h4505_4501, 64'h1000, 1'b1, 1'b0);
      expect_out("pair_c1", 1'b1, 32'h0000_4505, 64'h1002, 1'b1);

      drive(1'b1, 32'h0513_4501, 64'h1000, 1'b1, 1'b0);
      expect_out("strad_c0", 1'b1, 32'h0000_4501, 64'h1000, 1'b0);
      drive(1'b1, 32'h0513_4501, 64'h1000, 1'b1, 1'b0);
      expect_out("strad_bubble", 1'b0, 32'h0, 64'h0, 1'b1);
      drive(1'b1, 32'h4501_0000, 64'h1004, 1'b1, 1'b0);
      expect_out("strad_join", 1'b1, 32'h0000_0513, 64'h1002, 1'b0);
      drive(1'b1, 32'h4501_0000, 64'h1004, 1'b1, 1'b0);
      expect_out("strad_tail", 1'b1, 32'h0000_4501, 64'h1006, 1'b1);

      drive(1'b1, 32'h4505_ABCD, 64'h2002, 1'b1, 1'b0);
      expect_out("jump_hi", 1'b1, 32'h0000_4505, 64'h2002, 1'b1);

      drive(1'b1, 32'h4505_4501, 64'h1000, 1'b1, 1'b0);
      expect_out("bp_first", 1'b1, 32'h0000_4501, 64'h1000, 1'b0);
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 32'h4505_4501, 64'h1000, 1'b0, 1'b0);
         expect_out("bp_stall", 1'b1, 32'h0000_4505, 64'h1002, 1'b0);
      end
      drive(1'b1, 32'h4505_4501, 64'h1000, 1'b1, 1'b0);
      expect_out("bp_release", 1'b1, 32'h0000_4505, 64'h1002, 1'b1);

      drive(1'b1, 32'h0513_4501, 64'h2FFC, 1'b1, 1'b0);
      expect_out("fl_c0", 1'b1, 32'h0000_4501, 64'h2FFC, 1'b0);
      drive(1'b1, 32'h0513_4501, 64'h2FFC, 1'b0, 1'b0);
      expect_out("fl_bubble_noready", 1'b0, 32'h0, 64'h0, 1'b1);
      drive(1'b1, 32'hDEAD_BEEF, 64'h3000, 1'b1, 1'b1);
      expect_out("fl_flush", 1'b0, 32'h0, 64'h0, 1'b1);
      drive(1'b1, 32'h0000_0513, 64'h3000, 1'b1, 1'b0);
      expect_out("fl_after", 1'b1, 32'h0000_0513, 64'h3000, 1'b1);

      drive(1'b0, 32'h0000_0513, 64'h3004, 1'b1, 1'b0);
      expect_out("idle", 1'b0, 32'h0, 64'h0, 1'b0);

      run_random(64'h0000_0000_8000_0000, 1'b0, 40);
      run_random(64'h0000_1234_5678_9AB0, 1'b1, 40);
      run_random(64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 10);
      run_random(64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
